// File: rtl/dac_pkg.sv
// Shared constants for the DAC sample feeder.
// Default code width, mid-scale code, FIFO depth and divider width.
package dac_pkg;

    localparam int DAC_W = 8;
    localparam logic [DAC_W-1:0] DAC_MIDSCALE = 8'h80;
    localparam int DAC_DEPTH = 4;
    localparam int DAC_DIV_W = 8;

    // Occupancy counter width: one extra bit so DEPTH itself fits.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/dac_sync_fifo.sv
// Parameterised synchronous FIFO with valid/ready write and pop strobe.
// Ports: clk, rst, wr_valid/wr_data/wr_ready, pop, head, level.
module dac_sync_fifo
    import dac_pkg::*;
#(
    parameter int DATA_W = DAC_W,
    parameter int DEPTH  = DAC_DEPTH,
    parameter int AW     = $clog2(DEPTH),
    parameter int LW     = level_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [LW-1:0]     level
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              push;
    logic              pop_ok;
    logic [LW-1:0]     level_next;

    // Full blocks writes even when a pop happens in the same cycle.
    assign wr_ready = (level != LW'(DEPTH));
    assign push     = wr_valid && wr_ready;
    assign pop_ok   = pop && (level != '0);
    assign head     = mem[rd_ptr];

    always_comb begin
        level_next = level;
        unique case ({push, pop_ok})
            2'b10:   level_next = level + LW'(1);
            2'b01:   level_next = level - LW'(1);
            default: level_next = level;
        endcase
    end

    // Storage needs no reset; level alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap modulo DEPTH because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level <= level_next;
        end
    end

endmodule

// File: rtl/dac_sample_feeder.sv
// DAC front-end: buffers samples and releases one per div+1 cycles.
// Ports: clk, rst, wr_*, enable, div, clr_underrun, dac_code, dac_load, underrun, level.
module dac_sample_feeder
    import dac_pkg::*;
#(
    parameter int DATA_W = DAC_W,
    parameter int DEPTH  = DAC_DEPTH,
    parameter int DIV_W  = DAC_DIV_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_valid,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     wr_ready,
    input  logic                     enable,
    input  logic [DIV_W-1:0]         div,
    input  logic                     clr_underrun,
    output logic [DATA_W-1:0]        dac_code,
    output logic                     dac_load,
    output logic                     underrun,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [DATA_W-1:0] MIDSCALE = {1'b1, {(DATA_W-1){1'b0}}};

    logic [DIV_W-1:0]  cnt;
    logic [DIV_W-1:0]  cnt_next;
    logic              tick;
    logic              pop;
    logic              empty_tick;
    logic [DATA_W-1:0] head;
    logic [LW-1:0]     fifo_level;

    dac_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .pop      (pop),
        .head     (head),
        .level    (fifo_level)
    );

    assign level = fifo_level;

    // >= rather than == so a lowered div ends the current period at once.
    always_comb begin
        tick     = 1'b0;
        cnt_next = '0;
        if (enable) begin
            if (cnt >= div) begin
                tick     = 1'b1;
                cnt_next = '0;
            end else begin
                cnt_next = cnt + DIV_W'(1);
            end
        end
    end

    // Underrun looks at registered level only: a same-cycle write is not bypassed.
    assign pop        = tick && (fifo_level != '0);
    assign empty_tick = tick && (fifo_level == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dac_code <= MIDSCALE;
            dac_load <= 1'b0;
        end else begin
            dac_load <= pop;
            if (pop) begin
                dac_code <= head;
            end
        end
    end

    // Setting wins over a coincident clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            underrun <= 1'b0;
        end else if (empty_tick) begin
            underrun <= 1'b1;
        end else if (clr_underrun) begin
            underrun <= 1'b0;
        end
    end

endmodule
